seq_detector_prog: RTL and testbench

- Runtime-programmable serial pattern detector for the bit-serial receive path.
- Generalises the fixed 0111 detector to any pattern of length 1..MAX_LEN, loaded at run time.
- Adds input qualification, overlapping/non-overlapping mode, Mealy and registered match outputs, and a match counter.
- Sits after the bit recovery stage; feeds frame-sync and statistics logic.

---
 rtl/seq_detector_prog.sv | 157 +++++++++++++++
 tb/tb_seq_detector_prog.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// seq_detector_prog
//   Runtime-programmable serial pattern detector for the bit-serial receive
//   path. A pattern of 1..MAX_LEN bits is loaded at run time. Each qualified
//   input bit is compared against the pattern, and a match is flagged in the
//   same cycle as the bit that completes it.
//
// Optional feature macro: SEQ_DET_MATCH_CNT_EN
//   When defined, a saturating match counter is built.
//   When undefined, match_count and count_sat are tied to 0.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high; clears all state
//   cfg_load     in   single-cycle strobe capturing cfg_pattern / cfg_len
//   cfg_pattern  in   [MAX_LEN] pattern; bit [cfg_len-1] is received first
//   cfg_len      in   [LEN_W] pattern length, valid range 1..MAX_LEN
//   overlap_en   in   1 = overlapping detection, 0 = non-overlapping
//   in_valid     in   qualifies in_bit for this cycle
//   in_bit       in   serial data bit
//   match        out  combinational match on the completing valid bit
//   match_q      out  match delayed by one cycle
//   cfg_err      out  one-cycle pulse after an invalid load
//   armed        out  high while configured (FILL or RUN)
//   match_count  out  [CNT_W] saturating match count
//   count_sat    out  high while match_count is all ones
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               overlap_en,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic               match_q,
  output logic               cfg_err,
  output logic               armed,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  typedef enum logic [1:0] {UNCFG, FILL, RUN} state_t;

  localparam logic [LEN_W:0]   MAX_LEN_X = (LEN_W+1)'(MAX_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX  = LEN_W'(MAX_LEN);

  state_t             state_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;
  // Only MAX_LEN-1 past bits are kept: the live in_bit completes the window.
  logic [MAX_LEN-2:0] hist_q;
  logic               cfg_err_q;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_inc;
  logic               fill_ok;
  logic               cfg_ok;
  logic               window_eq;

  assign cand      = {hist_q, in_bit};
  assign fill_inc  = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign fill_ok   = (fill_inc >= {1'b0, len_q});
  assign cfg_ok    = (cfg_len != '0) && ({1'b0, cfg_len} <= MAX_LEN_X);
  assign armed     = (state_q != UNCFG);
  assign cfg_err   = cfg_err_q;

  // Only the low len_q bits of the window take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign window_eq = (((cand ^ pattern_q) & len_mask) == '0);

  // A load in the same cycle wins over the data bit, so it suppresses match.
  assign match = in_valid && !cfg_load && armed && fill_ok && window_eq;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= UNCFG;
      pattern_q <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      hist_q    <= '0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      match_q   <= match;
      cfg_err_q <= 1'b0;
      if (cfg_load) begin
        if (cfg_ok) begin
          pattern_q <= cfg_pattern;
          len_q     <= cfg_len;
          hist_q    <= '0;
          fill_q    <= '0;
          state_q   <= FILL;
        end else begin
          cfg_err_q <= 1'b1;
          len_q     <= '0;
          state_q   <= UNCFG;
        end
      end else if (in_valid && armed) begin
        hist_q <= cand[MAX_LEN-2:0];
        if (match && !overlap_en) begin
          // Non-overlapping: the next match must be built from fresh bits.
          fill_q  <= '0;
          state_q <= FILL;
        end else begin
          if (fill_q != FILL_MAX) begin
            fill_q <= fill_inc[LEN_W-1:0];
          end
          if (fill_ok) begin
            state_q <= RUN;
          end
        end
      end
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (cfg_load && cfg_ok) begin
      count_d = '0;
    end else if (match && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
  assign count_sat   = &count_q;
`else
  assign match_count = '0;
  assign count_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog
//   Table-driven bench for seq_detector_prog (MAX_LEN=8, LEN_W=4, CNT_W=2).
//   Each record holds one cycle of inputs plus the expected match for that
//   cycle and the expected registered outputs after the clock edge. The
//   expected counter value is kept as a raw match count and mapped through
//   the counter model, which depends on SEQ_DET_MATCH_CNT_EN.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               overlap_en;
  logic               in_valid;
  logic               in_bit;
  logic               match;
  logic               match_q;
  logic               cfg_err;
  logic               armed;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .overlap_en(overlap_en), .in_valid(in_valid), .in_bit(in_bit),
    .match(match), .match_q(match_q), .cfg_err(cfg_err), .armed(armed),
    .match_count(match_count), .count_sat(count_sat)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       load;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic       vld;
    logic       b;
    logic       m;
    logic       err;
    logic       arm;
    int         cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t tbl2[$];
  int   n_vec  = 0;
  int   n_cmp  = 0;
  int   n_miss = 0;

  // Counter model: saturates at 2^CNT_W-1, or stays 0 without the counter.
  function automatic int cexp(input int raw);
`ifdef SEQ_DET_MATCH_CNT_EN
    return (raw > 3) ? 3 : raw;
`else
    return 0 * raw;
`endif
  endfunction

  function automatic void v(ref vec_t q[$], input logic load, input logic [7:0] pat,
                            input logic [3:0] len, input logic ov, input logic vld,
                            input logic b, input logic m, input logic err,
                            input logic arm, input int cnt);
    vec_t t;
    t.load = load; t.pat = pat; t.len = len; t.ov = ov; t.vld = vld; t.b = b;
    t.m = m; t.err = err; t.arm = arm; t.cnt = cnt;
    q.push_back(t);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clock);
    cfg_load = t.load; cfg_pattern = t.pat; cfg_len = t.len;
    overlap_en = t.ov; in_valid = t.vld; in_bit = t.b;
    #1;
    chk("match", idx, 32'(match), 32'(t.m));
    @(posedge clock);
    #1;
    chk("match_q", idx, 32'(match_q), 32'(t.m));
    chk("cfg_err", idx, 32'(cfg_err), 32'(t.err));
    chk("armed", idx, 32'(armed), 32'(t.arm));
    chk("match_count", idx, 32'(match_count), 32'(cexp(t.cnt)));
    chk("count_sat", idx, 32'(count_sat), 32'(cexp(t.cnt) == 3));
    n_vec++;
  endtask

  task automatic idle_inputs();
    cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    overlap_en = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_match"}, -1, 32'(match), 32'd0);
    chk({nm, "_match_q"}, -1, 32'(match_q), 32'd0);
    chk({nm, "_cfg_err"}, -1, 32'(cfg_err), 32'd0);
    chk({nm, "_armed"}, -1, 32'(armed), 32'd0);
    chk({nm, "_match_count"}, -1, 32'(match_count), 32'd0);
    chk({nm, "_count_sat"}, -1, 32'(count_sat), 32'd0);
  endtask

  initial begin
    // 0111, overlap: matches on bits 4 and 9, then an idle cycle.
    v(tbl, 1, 8'h07, 4, 1, 0, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1);
    v(tbl, 0, 0, 0, 1, 1, 1, 1, 0, 1, 2);
    v(tbl, 0, 0, 0, 1, 0, 1, 0, 0, 1, 2);
    // 101 overlapping: bits 3 and 5.
    v(tbl, 1, 8'h05, 3, 1, 0, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
    v(tbl, 0, 0, 0, 1, 1, 1, 1, 0, 1, 2);
    // 101 non-overlapping: bit 3 only.
    v(tbl, 1, 8'h05, 3, 0, 0, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1);
    v(tbl, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    v(tbl, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1);
    // 0111 with a 3-cycle invalid gap before the final bit.
    v(tbl, 1, 8'h07, 4, 1, 0, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1);
    // Invalid loads (len 0, len 9): error pulse, disarmed, count kept.
    v(tbl, 1, 8'h07, 0, 1, 0, 0, 0, 1, 0, 1);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    v(tbl, 1, 8'h07, 9, 1, 0, 0, 0, 1, 0, 1);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    v(tbl, 1, 8'h07, 4, 1, 0, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1);
    // Reload colliding with a completing bit: load wins, history restarts.
    v(tbl, 1, 8'h07, 4, 1, 0, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 1, 8'h07, 4, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1);
    // Length 1.
    v(tbl, 1, 8'h01, 1, 1, 0, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
    v(tbl, 0, 0, 0, 1, 1, 1, 1, 0, 1, 2);
    // Length MAX_LEN: 1010_0101, MSB first.
    v(tbl, 1, 8'hA5, 8, 1, 0, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1);
    // Saturation: five matches on a length-1 pattern.
    v(tbl, 1, 8'h01, 1, 1, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) v(tbl, 0, 0, 0, 1, 1, 1, 1, 0, 1, k);
    // Lead-in to the mid-stream reset: a match so match_q and count are set.
    v(tbl, 1, 8'h07, 4, 1, 0, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1);

    // After reset: unconfigured, bits ignored, until a reload.
    v(tbl2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    v(tbl2, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    v(tbl2, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    v(tbl2, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    v(tbl2, 1, 8'h07, 4, 1, 0, 0, 0, 0, 1, 0);
    v(tbl2, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    v(tbl2, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl2, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    v(tbl2, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1);

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i], i);

    // Asynchronous reset between clock edges, right after a match.
    @(negedge clock);
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(negedge clock);
    reset = 1'b0;

    foreach (tbl2[i]) apply(tbl2[i], 1000 + i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
